// File: rtl/wsc_sequencer.sv
// ---------------------------------------------------------------------------
// wsc_sequencer
//
// Drives the wrapper serial control (WSC) strobes of a wrapper around a core
// from a simple command/response interface. Each command is either a
// WIR load (cmd_op=0, fixed INSTR_WIDTH bits) or a data-register scan
// (cmd_op=1, cmd_len bits clamped to DATA_WIDTH). The sequencer walks
// IDLE -> CAPTURE -> SHIFT -> UPDATE -> DONE, shifting cmd_data out on wsi
// (bit 0 first) while collecting wso into rsp_data (bit k from shift cycle k).
// An abort in CAPTURE or SHIFT ends the operation in DONE with no update
// pulse and rsp_aborted set.
//
// Ports
//   WRCK         in   wrapper clock, all state changes on its rising edge
//   WRSTN        in   asynchronous active-low reset
//   cmd_valid    in   command offered
//   cmd_ready    out  high only in IDLE
//   cmd_op       in   0 = load WIR, 1 = scan data register
//   cmd_len      in   data-scan bit count (ignored for WIR loads)
//   cmd_data     in   bits to shift in, bit 0 first
//   abort        in   synchronous abort request (CAPTURE/SHIFT only)
//   SelectWIR    out  WSC select, high for WIR operations while scanning
//   CaptureWR    out  WSC capture strobe
//   ShiftWR      out  WSC shift enable
//   UpdateWR     out  WSC update strobe
//   wsi          out  serial data to wrapper, 0 unless shifting
//   wso          in   serial data from wrapper
//   rsp_valid    out  response available (DONE)
//   rsp_ready    in   response consumed, honoured only in DONE
//   rsp_data     out  bits shifted out of the wrapper
//   rsp_aborted  out  operation was aborted
// ---------------------------------------------------------------------------
module wsc_sequencer #(
    parameter int unsigned INSTR_WIDTH = 3,
    parameter int unsigned DATA_WIDTH  = 20,
    parameter int unsigned LEN_W       = 5
) (
    input  logic                  WRCK,
    input  logic                  WRSTN,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_op,
    input  logic [LEN_W-1:0]      cmd_len,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    input  logic                  abort,
    output logic                  SelectWIR,
    output logic                  CaptureWR,
    output logic                  ShiftWR,
    output logic                  UpdateWR,
    output logic                  wsi,
    input  logic                  wso,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_aborted
);

    // Counter holds 0..DATA_WIDTH; index slice addresses 0..DATA_WIDTH-1.
    localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);
    localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        SHIFT,
        UPDATE,
        DONE
    } state_e;

    // Control state
    state_e                state_q,   state_d;
    logic                  op_q,      op_d;
    logic [CNT_W-1:0]      len_q,     len_d;
    logic [CNT_W-1:0]      cnt_q,     cnt_d;
    logic [DATA_WIDTH-1:0] data_q,    data_d;
    logic [DATA_WIDTH-1:0] rsp_q,     rsp_d;
    logic                  aborted_q, aborted_d;

    // Registered outputs
    logic                  ready_q,   ready_d;
    logic                  sel_q,     sel_d;
    logic                  cap_q,     cap_d;
    logic                  shift_q,   shift_d;
    logic                  upd_q,     upd_d;
    logic                  wsi_q,     wsi_d;
    logic                  valid_q,   valid_d;

    logic [CNT_W-1:0]      eff_len;
    logic                  in_scan;

    // Effective length latched on accept: WIR loads use the fixed WIR
    // length, data scans clamp the requested length to the longest chain.
    always_comb begin
        if (!cmd_op) begin
            eff_len = CNT_W'(INSTR_WIDTH);
        end else if (32'(cmd_len) > DATA_WIDTH) begin
            eff_len = CNT_W'(DATA_WIDTH);
        end else begin
            eff_len = CNT_W'(cmd_len);
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        rsp_d     = rsp_q;
        aborted_d = aborted_q;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d   = CAPTURE;
                    op_d      = cmd_op;
                    len_d     = eff_len;
                    data_d    = cmd_data;
                    cnt_d     = '0;
                    rsp_d     = '0;
                    aborted_d = 1'b0;
                end
            end
            CAPTURE: begin
                if (abort) begin
                    state_d   = DONE;
                    aborted_d = 1'b1;
                end else if (len_q == '0) begin
                    state_d = UPDATE;
                end else begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // An abort edge does not sample wso: only completed shift
                // cycles contribute to the response.
                if (abort) begin
                    state_d   = DONE;
                    aborted_d = 1'b1;
                end else begin
                    rsp_d[cnt_q[IDX_W-1:0]] = wso;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == len_q) begin
                        state_d = UPDATE;
                    end
                end
            end
            UPDATE: begin
                state_d = DONE;
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so that the registered
    // strobes line up with the state they belong to.
    always_comb begin
        in_scan   = (state_d == CAPTURE) || (state_d == SHIFT) || (state_d == UPDATE);
        ready_d   = (state_d == IDLE);
        sel_d     = in_scan && !op_d;
        cap_d     = (state_d == CAPTURE);
        shift_d   = (state_d == SHIFT);
        upd_d     = (state_d == UPDATE);
        valid_d   = (state_d == DONE);
        // cnt_d is the index of the upcoming shift cycle.
        wsi_d     = 1'b0;
        if (state_d == SHIFT) begin
            wsi_d = data_q[cnt_d[IDX_W-1:0]];
        end
    end

    always_ff @(posedge WRCK or negedge WRSTN) begin
        if (!WRSTN) begin
            state_q   <= IDLE;
            op_q      <= 1'b0;
            len_q     <= '0;
            cnt_q     <= '0;
            data_q    <= '0;
            rsp_q     <= '0;
            aborted_q <= 1'b0;
            ready_q   <= 1'b1;
            sel_q     <= 1'b0;
            cap_q     <= 1'b0;
            shift_q   <= 1'b0;
            upd_q     <= 1'b0;
            wsi_q     <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            rsp_q     <= rsp_d;
            aborted_q <= aborted_d;
            ready_q   <= ready_d;
            sel_q     <= sel_d;
            cap_q     <= cap_d;
            shift_q   <= shift_d;
            upd_q     <= upd_d;
            wsi_q     <= wsi_d;
            valid_q   <= valid_d;
        end
    end

    assign cmd_ready   = ready_q;
    assign SelectWIR   = sel_q;
    assign CaptureWR   = cap_q;
    assign ShiftWR     = shift_q;
    assign UpdateWR    = upd_q;
    assign wsi         = wsi_q;
    assign rsp_valid   = valid_q;
    assign rsp_data    = rsp_q;
    assign rsp_aborted = aborted_q;

endmodule

// File: tb/tb_wsc_sequencer.sv
module tb_wsc_sequencer;

    localparam int DW = 20;

    logic          WRCK  = 1'b0;
    logic          WRSTN = 1'b0;
    logic          cmd_valid, cmd_ready, cmd_op;
    logic [4:0]    cmd_len;
    logic [DW-1:0] cmd_data;
    logic          abort;
    logic          SelectWIR, CaptureWR, ShiftWR, UpdateWR, wsi, wso;
    logic          rsp_valid, rsp_ready, rsp_aborted;
    logic [DW-1:0] rsp_data;

    wsc_sequencer #(
        .INSTR_WIDTH(3),
        .DATA_WIDTH (DW),
        .LEN_W      (5)
    ) dut (
        .WRCK       (WRCK),
        .WRSTN      (WRSTN),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_len    (cmd_len),
        .cmd_data   (cmd_data),
        .abort      (abort),
        .SelectWIR  (SelectWIR),
        .CaptureWR  (CaptureWR),
        .ShiftWR    (ShiftWR),
        .UpdateWR   (UpdateWR),
        .wsi        (wsi),
        .wso        (wso),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_aborted(rsp_aborted)
    );

    always #5 WRCK = ~WRCK;

    // Loopback wrapper chain: wso is its LSB, wsi enters at the MSB.
    logic [DW-1:0] lb, lb_pre;
    logic          lb_load;
    always @(posedge WRCK) begin
        if (lb_load)      lb <= lb_pre;
        else if (ShiftWR) lb <= {wsi, lb[DW-1:1]};
    end
    assign wso = lb[0];

    typedef struct {
        logic          op;
        logic [4:0]    len;
        logic [DW-1:0] data;
        logic [DW-1:0] pre;
        logic [DW-1:0] exp_rsp;
        int            exp_shifts;
        int            exp_upds;
        int            exp_lat;
        logic          exp_sel;
        logic          exp_abort;
        int            abort_after;  // completed shift cycles before abort, -1 = none
        logic          tail_abort;   // hold abort high in UPDATE and DONE
        int            hold;         // DONE cycles with rsp_ready=0
    } vec_t;

    typedef struct {
        logic [DW-1:0] rsp;
        logic          aborted;
    } sb_t;

    sb_t  sbq[$];
    vec_t vecs[10];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_op(input vec_t v);
        int   cyc, shifts, caps, upds, bad, hbad;
        logic timeout;
        sb_t  exp_e, got;
        logic [DW-1:0] snap;
        logic snap_ab;
        cyc = 0; shifts = 0; caps = 0; upds = 0; bad = 0; hbad = 0;
        timeout = 1'b1;

        @(negedge WRCK);
        abort = 1'b0;
        chk("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = v.op;
        cmd_len   = v.len;
        cmd_data  = v.data;
        lb_pre    = v.pre;
        lb_load   = 1'b1;
        @(posedge WRCK);
        #1;
        cmd_valid = 1'b0;
        lb_load   = 1'b0;
        cmd_data  = ~v.data;
        exp_e.rsp     = v.exp_rsp;
        exp_e.aborted = v.exp_abort;
        sbq.push_back(exp_e);

        while (cyc < 40) begin
            @(negedge WRCK);
            cyc++;
            abort = 1'b0;
            if (rsp_valid) begin
                timeout = 1'b0;
                break;
            end
            if (int'(CaptureWR) + int'(ShiftWR) + int'(UpdateWR) > 1) bad++;
            if (!ShiftWR && wsi) bad++;
            if (cmd_ready) bad++;
            if (SelectWIR !== v.exp_sel) bad++;
            if (ShiftWR && shifts < DW && wsi !== v.data[shifts]) bad++;
            if ((CaptureWR || ShiftWR) && shifts == v.abort_after) abort = 1'b1;
            if (UpdateWR && v.tail_abort) abort = 1'b1;
            caps   += int'(CaptureWR);
            shifts += int'(ShiftWR);
            upds   += int'(UpdateWR);
        end

        chk("timeout",      timeout, 0);
        chk("latency",      cyc - 1, v.exp_lat);
        chk("capture_cnt",  caps, 1);
        chk("shift_cnt",    shifts, v.exp_shifts);
        chk("update_cnt",   upds, v.exp_upds);
        chk("strobe_rules", bad, 0);
        chk("sb_size",      sbq.size(), 1);
        if (sbq.size() > 0) begin
            got = sbq.pop_front();
            chk("rsp_data",    rsp_data, got.rsp);
            chk("rsp_aborted", rsp_aborted, got.aborted);
        end

        snap    = rsp_data;
        snap_ab = rsp_aborted;
        for (int h = 0; h < v.hold; h++) begin
            cmd_valid = 1'b1;
            cmd_op    = ~v.op;
            cmd_len   = 5'd3;
            rsp_ready = 1'b0;
            abort     = v.tail_abort;
            @(posedge WRCK);
            @(negedge WRCK);
            if (!rsp_valid || rsp_data !== snap || rsp_aborted !== snap_ab || cmd_ready ||
                CaptureWR || ShiftWR || UpdateWR || SelectWIR || wsi) hbad++;
        end
        chk("done_hold", hbad, 0);

        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge WRCK);
        #1;
        chk("release", {cmd_ready, rsp_valid}, 2'b10);
        rsp_ready = 1'b0;
        abort     = 1'b0;
        @(posedge WRCK);
        #1;
        chk("no_queue", {cmd_ready, CaptureWR}, 2'b10);
    endtask

    initial begin
        // op len data pre exp_rsp shifts upds lat sel abort abort_after tail hold
        vecs[0] = '{1'b0, 5'd9,  20'h00005, 20'hA5A5A, 20'h00002, 3,  1, 5,  1'b1, 1'b0, -1, 1'b0, 1};
        vecs[1] = '{1'b1, 5'd20, 20'h3C3C3, 20'hA5A5A, 20'hA5A5A, 20, 1, 22, 1'b0, 1'b0, -1, 1'b0, 7};
        vecs[2] = '{1'b1, 5'd31, 20'hFFFFF, 20'h5A5A5, 20'h5A5A5, 20, 1, 22, 1'b0, 1'b0, -1, 1'b0, 1};
        vecs[3] = '{1'b1, 5'd0,  20'hFFFFF, 20'hFFFFF, 20'h00000, 0,  1, 2,  1'b0, 1'b0, -1, 1'b0, 1};
        vecs[4] = '{1'b1, 5'd10, 20'h00155, 20'h00F0F, 20'h0030F, 10, 1, 12, 1'b0, 1'b0, -1, 1'b0, 1};
        vecs[5] = '{1'b1, 5'd10, 20'h002AA, 20'hFFFFF, 20'h0000F, 5,  0, 6,  1'b0, 1'b1, 4,  1'b0, 2};
        vecs[6] = '{1'b1, 5'd5,  20'h0001F, 20'h0000A, 20'h00000, 0,  0, 1,  1'b0, 1'b1, 0,  1'b0, 1};
        vecs[7] = '{1'b1, 5'd6,  20'h00015, 20'h0002C, 20'h0002C, 6,  1, 8,  1'b0, 1'b0, -1, 1'b1, 3};
        vecs[8] = '{1'b0, 5'd0,  20'h00006, 20'h00005, 20'h00005, 3,  1, 5,  1'b1, 1'b0, -1, 1'b0, 1};
        vecs[9] = '{1'b1, 5'd1,  20'h00001, 20'hFFFFE, 20'h00000, 1,  1, 3,  1'b0, 1'b0, -1, 1'b0, 1};

        cmd_valid = 1'b0; cmd_op = 1'b0; cmd_len = '0; cmd_data = '0;
        abort = 1'b0; rsp_ready = 1'b0; lb_pre = '0; lb_load = 1'b0;

        // Reset state
        repeat (3) @(posedge WRCK);
        @(negedge WRCK);
        chk("reset_state",
            {SelectWIR, CaptureWR, ShiftWR, UpdateWR, wsi, rsp_valid, rsp_aborted, cmd_ready},
            8'b0000_0001);
        chk("reset_rsp_data", rsp_data, 0);
        @(posedge WRCK);
        #2 WRSTN = 1'b1;

        foreach (vecs[i]) run_op(vecs[i]);

        // Asynchronous reset in the middle of a shift
        @(negedge WRCK);
        cmd_valid = 1'b1; cmd_op = 1'b1; cmd_len = 5'd20; cmd_data = 20'hABCDE;
        lb_pre = 20'hFFFFF; lb_load = 1'b1;
        @(posedge WRCK);
        #1;
        cmd_valid = 1'b0; lb_load = 1'b0;
        repeat (4) @(posedge WRCK);
        #1;
        chk("shift_before_reset", ShiftWR, 1);
        #2 WRSTN = 1'b0;
        #1;
        chk("async_reset_state",
            {SelectWIR, CaptureWR, ShiftWR, UpdateWR, wsi, rsp_valid, rsp_aborted, cmd_ready},
            8'b0000_0001);
        chk("async_reset_rsp_data", rsp_data, 0);
        repeat (2) @(posedge WRCK);
        #2 WRSTN = 1'b1;
        run_op(vecs[0]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/wsc_sequencer.md
WSC_SEQUENCER -- requirements
Module: wsc_sequencer

Interface
REQ-001 Parameters SHALL be:
- INSTR_WIDTH, default 3: WIR length in bits.
- DATA_WIDTH, default 20: longest data register (WBR chain).
- LEN_W, default 5: width of cmd_len.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- WRCK  in  1  wrapper clock; all state changes on its rising edge.
- WRSTN  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  1  0 = load WIR, 1 = scan data register.
- cmd_len  in  LEN_W  data-scan bit count.
- cmd_data  in  DATA_WIDTH  bits to shift in; bit 0 goes first.
- abort  in  1  synchronous abort request.
- SelectWIR  out  1  WSC select, to wrapper.
- CaptureWR  out  1  WSC capture strobe, to wrapper.
- ShiftWR  out  1  WSC shift enable, to wrapper.
- UpdateWR  out  1  WSC update strobe, to wrapper.
- wsi  out  1  serial data to wrapper.
- wso  in  1  serial data from wrapper.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_data  out  DATA_WIDTH  bits shifted out of the wrapper.
- rsp_aborted  out  1  operation was aborted.

Function
REQ-003 States SHALL be IDLE, CAPTURE, SHIFT, UPDATE, DONE; one-hot or binary encoding is free.
REQ-004 cmd_ready SHALL be 1 only in IDLE; a command is accepted on a WRCK edge with cmd_valid=1 and cmd_ready=1, and the state goes to CAPTURE.
REQ-005 On accept, the sequencer SHALL latch op, cmd_data and the effective length:
- op=0: INSTR_WIDTH, with cmd_len ignored.
- op=1: min(cmd_len, DATA_WIDTH).
REQ-006 SelectWIR SHALL equal the latched op inverted (1 for WIR) in CAPTURE, SHIFT and UPDATE, and SHALL be 0 in IDLE and DONE.
REQ-007 CAPTURE SHALL last exactly one cycle with CaptureWR=1.
- Next state is SHIFT, or UPDATE if the effective length is 0.
REQ-008 SHIFT SHALL last exactly effective-length cycles with ShiftWR=1.
- In shift cycle k (k = 0..len-1), wsi SHALL equal latched data bit k.
- On the closing edge of cycle k, wso SHALL be sampled into rsp_data bit k.
REQ-009 UPDATE SHALL last exactly one cycle with UpdateWR=1; the next state is DONE.
REQ-010 CaptureWR, ShiftWR and UpdateWR SHALL be mutually exclusive and 0 outside their own state.
REQ-011 wsi SHALL be 0 whenever ShiftWR=0.
REQ-012 In DONE, rsp_valid SHALL be 1 and rsp_data and rsp_aborted SHALL be stable.
- The sequencer returns to IDLE on the edge where rsp_ready=1.
- rsp_ready outside DONE SHALL be ignored.
REQ-013 rsp_data bits at index >= effective length SHALL be 0.
REQ-014 abort=1 in CAPTURE or SHIFT SHALL move the sequencer to DONE on that edge.
- No UpdateWR pulse is issued.
- rsp_aborted=1.
- rsp_data holds the bits sampled so far, with the remaining bits 0.
REQ-015 abort SHALL be ignored in IDLE, UPDATE and DONE, and rsp_aborted=0 for completed operations.
REQ-016 Total latency from accept edge to rsp_valid=1 SHALL be len+2 cycles for a non-aborted operation.
- Example: WIR load = 5 cycles.
REQ-017 cmd_valid while busy SHALL have no effect; the command is not queued.

Reset
REQ-018 WRSTN=0 SHALL immediately, without a clock, force the following, regardless of state or mid-shift position:
- state IDLE
- SelectWIR=0, CaptureWR=0, ShiftWR=0, UpdateWR=0
- wsi=0, rsp_valid=0, rsp_aborted=0
- rsp_data all 0
- cmd_ready=1
REQ-019 After WRSTN deasserts, the first command SHALL be acceptable on the first WRCK edge.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- WIR load: op=0, cmd_data=3'b101, cmd_len=9 -> CaptureWR 1 cycle; ShiftWR 3 cycles with wsi 1,0,1; UpdateWR 1 cycle; SelectWIR=1 throughout; rsp_valid 5 cycles after accept.
- Data scan: op=1, len=20, wso driven from a loopback 20-bit shift register preloaded 0xA5A5A -> rsp_data=0xA5A5A, 20 ShiftWR cycles, SelectWIR=0.
- Clamp and zero length: len=31 -> exactly 20 shift cycles. len=0 -> CaptureWR then UpdateWR on consecutive cycles, rsp_data=0.
- Abort after 4 shift cycles of a len=10 scan with wso=1 -> no UpdateWR, rsp_aborted=1, rsp_data=0x00F.
- Reset mid-SHIFT, with WRSTN low between clock edges -> all strobes 0 immediately, cmd_ready=1; a following WIR load completes normally.
- Backpressure: hold rsp_ready=0 for 7 cycles in DONE -> rsp_valid and rsp_data stable, cmd_ready=0, new cmd_valid ignored; IDLE one edge after rsp_ready=1.
